// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Hazard-detection and operand-forwarding unit for the pipelined MIPS core.
// A scoreboard shift register records the register writes that are in flight.
// It has one entry per post-decode stage: entry 0 is EX and entry STAGES-1
// is WB. From this scoreboard the unit produces the decode-stage stall, the
// per-operand forwarding selects and a saturating stall-cycle counter.
//
// Optional feature macro: HAZARD_FORWARD_EN
//   defined   : forwarding selects are active. Only a load whose data is
//               not yet available (entry index < LOAD_STAGE) causes a stall.
//   undefined : any dependence on an in-flight write stalls until the
//               producer retires. The forwarding selects are tied to 0.
//
// Parameters
//   STAGES     tracked post-decode stages (minimum 2)
//   LOAD_STAGE lowest entry index from which load data may be forwarded
//   CNT_W      stall counter width
//
// Ports
//   clk            clock, all state on the rising edge
//   rst_b          asynchronous active-low reset
//   id_valid_i     ID holds a valid instruction
//   id_rs_num_i    rs source register number
//   id_rt_num_i    rt source register number
//   id_rs_used_i   rs is actually read
//   id_rt_used_i   rt is actually read
//   id_rd_num_i    destination register number
//   id_reg_write_i instruction writes id_rd_num_i
//   id_is_load_i   instruction is a load
//   mem_busy_i     cache not done; scoreboard and counter frozen
//   flush_i        kill instruction in ID
//   stall_o        hold PC and IF/ID, inject a bubble into EX
//   fwd_rs_sel_o   rs operand source: 0 = regfile, k = result of entry k-1
//   fwd_rt_sel_o   rt operand source: 0 = regfile, k = result of entry k-1
//   stall_count_o  saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst_b,
    input  logic                             id_valid_i,
    input  logic [4:0]                       id_rs_num_i,
    input  logic [4:0]                       id_rt_num_i,
    input  logic                             id_rs_used_i,
    input  logic                             id_rt_used_i,
    input  logic [4:0]                       id_rd_num_i,
    input  logic                             id_reg_write_i,
    input  logic                             id_is_load_i,
    input  logic                             mem_busy_i,
    input  logic                             flush_i,
    output logic                             stall_o,
    output logic [$clog2(STAGES+1)-1:0]      fwd_rs_sel_o,
    output logic [$clog2(STAGES+1)-1:0]      fwd_rt_sel_o,
    output logic [CNT_W-1:0]                 stall_count_o
);

    localparam int SEL_W = $clog2(STAGES + 1);

    typedef struct packed {
        logic             hit;
        logic             ld;
        logic [SEL_W-1:0] idx;
    } match_t;

    // Scoreboard state
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] ld_q,  ld_d;
    logic [4:0]        rd_q [STAGES];
    logic [4:0]        rd_d [STAGES];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    match_t            rs_m_s, rt_m_s;
    logic              rs_haz_s, rt_haz_s;
    logic [SEL_W-1:0]  rs_sel_s, rt_sel_s;
    logic              stall_s, issue_s;

    // The loop runs from the oldest entry down, so the youngest
    // (lowest-index) producer is the one left in the result.
    function automatic match_t find_match(input logic [4:0] num, input logic used);
        match_t m;
        m = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (used && vld_q[k] && (rd_q[k] == num)) begin
                m.hit = 1'b1;
                m.ld  = ld_q[k];
                m.idx = SEL_W'(k);
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    // Operand match, hazard classification and forwarding selects
    always_comb begin
        rs_m_s = find_match(id_rs_num_i, id_rs_used_i);
        rt_m_s = find_match(id_rt_num_i, id_rt_used_i);
`ifdef HAZARD_FORWARD_EN
        // A load still below LOAD_STAGE has no data to forward yet.
        rs_haz_s = rs_m_s.hit & rs_m_s.ld & (rs_m_s.idx < SEL_W'(LOAD_STAGE));
        rt_haz_s = rt_m_s.hit & rt_m_s.ld & (rt_m_s.idx < SEL_W'(LOAD_STAGE));
        if (rs_m_s.hit && !rs_haz_s && !flush_i) begin
            rs_sel_s = rs_m_s.idx + SEL_W'(1);
        end else begin
            rs_sel_s = SEL_W'(0);
        end
        if (rt_m_s.hit && !rt_haz_s && !flush_i) begin
            rt_sel_s = rt_m_s.idx + SEL_W'(1);
        end else begin
            rt_sel_s = SEL_W'(0);
        end
`else
        rs_haz_s = rs_m_s.hit;
        rt_haz_s = rt_m_s.hit;
        rs_sel_s = SEL_W'(0);
        rt_sel_s = SEL_W'(0);
`endif
        stall_s = (rs_haz_s | rt_haz_s) & id_valid_i & ~flush_i;
        issue_s = id_valid_i & ~stall_s & ~flush_i;
    end

    // stall and selects must act in the same cycle, so they are not registered
    always_comb begin
        stall_o       = stall_s;
        fwd_rs_sel_o  = rs_sel_s;
        fwd_rt_sel_o  = rt_sel_s;
        stall_count_o = cnt_q;
    end

    // Scoreboard shift and stall counter next state; mem_busy freezes both
    always_comb begin
        vld_d = vld_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (!mem_busy_i) begin
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                ld_d[k]  = ld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            if (issue_s) begin
                // r0 is hard-wired to zero, so writes to it never create a dependence
                vld_d[0] = id_reg_write_i & (id_rd_num_i != 5'd0);
                ld_d[0]  = id_is_load_i;
                rd_d[0]  = id_rd_num_i;
            end else begin
                vld_d[0] = 1'b0;
                ld_d[0]  = 1'b0;
                rd_d[0]  = 5'd0;
            end
            if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vld_q <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k] <= 5'd0;
            end
        end else begin
            vld_q <= vld_d;
            ld_q  <= ld_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k] <= rd_d[k];
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed self-checking bench for hazard_unit with default parameters
// (STAGES=3, LOAD_STAGE=1, CNT_W=16). Expected values are hand-derived.
// Where the two builds differ, the expectations follow HAZARD_FORWARD_EN.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    logic        clk;
    logic        rst_b;
    logic        id_valid;
    logic [4:0]  id_rs_num;
    logic [4:0]  id_rt_num;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [4:0]  id_rd_num;
    logic        id_reg_write;
    logic        id_is_load;
    logic        mem_busy;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic [15:0] stall_count;

    int checks;
    int errors;
    int exp_cnt;

    hazard_unit dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .id_valid_i     (id_valid),
        .id_rs_num_i    (id_rs_num),
        .id_rt_num_i    (id_rt_num),
        .id_rs_used_i   (id_rs_used),
        .id_rt_used_i   (id_rt_used),
        .id_rd_num_i    (id_rd_num),
        .id_reg_write_i (id_reg_write),
        .id_is_load_i   (id_is_load),
        .mem_busy_i     (mem_busy),
        .flush_i        (flush),
        .stall_o        (stall),
        .fwd_rs_sel_o   (fwd_rs_sel),
        .fwd_rt_sel_o   (fwd_rt_sel),
        .stall_count_o  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                          input logic rtu, input logic [4:0] rd, input logic rw,
                          input logic ld);
        id_valid     = 1'b1;
        id_rs_num    = rs;
        id_rs_used   = rsu;
        id_rt_num    = rt;
        id_rt_used   = rtu;
        id_rd_num    = rd;
        id_reg_write = rw;
        id_is_load   = ld;
    endtask

    task automatic id_clear();
        id_valid     = 1'b0;
        id_rs_num    = 5'd0;
        id_rs_used   = 1'b0;
        id_rt_num    = 5'd0;
        id_rt_used   = 1'b0;
        id_rd_num    = 5'd0;
        id_reg_write = 1'b0;
        id_is_load   = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_cnt  = 0;
        rst_b    = 1'b0;
        mem_busy = 1'b0;
        flush    = 1'b0;
        id_clear();

        // Reset state
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_rs_sel", fwd_rs_sel, 0);
        chk("rst_count", stall_count, 0);
        @(posedge clk);
        #1 rst_b = 1'b1;

        // ALU producer r3 followed by readers of r3
        id_set(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        #2 chk("t1_prod_stall", stall, 0);
        step();
        id_set(5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
        #2;
`ifdef HAZARD_FORWARD_EN
        chk("t1_rd1_stall", stall, 0);
        chk("t1_rd1_rs_sel", fwd_rs_sel, 1);
        chk("t1_rd1_rt_sel", fwd_rt_sel, 0);
        step();
        id_set(5'd3, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
        #2;
        chk("t1_rd2_stall", stall, 0);
        chk("t1_rd2_rs_sel", fwd_rs_sel, 2);
        chk("t1_rd2_rt_sel", fwd_rt_sel, 1);
`else
        chk("t1_stall_c1", stall, 1);
        chk("t1_rs_sel_c1", fwd_rs_sel, 0);
        step();
        #2 chk("t1_stall_c2", stall, 1);
        step();
        #2 chk("t1_stall_c3", stall, 1);
        step();
        #2 chk("t1_stall_c4", stall, 0);
        chk("t1_rs_sel_c4", fwd_rs_sel, 0);
        chk("t1_rt_sel_c4", fwd_rt_sel, 0);
        exp_cnt = 3;
`endif
        chk("t1_count", stall_count, exp_cnt);
        step();
        id_clear();
        repeat (4) step();

        // r0 writes are never tracked; unused source fields never match
        id_set(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        step();
        id_set(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        #2;
        chk("t2_r0_stall", stall, 0);
        chk("t2_r0_rs_sel", fwd_rs_sel, 0);
        chk("t2_r0_rt_sel", fwd_rt_sel, 0);
        step();
        id_set(5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        id_set(5'd8, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        #2;
        chk("t2_unused_stall", stall, 0);
        chk("t2_unused_rs_sel", fwd_rs_sel, 0);
        step();
        id_clear();
        repeat (4) step();

        // Load-use on rt with mem_busy held for 4 cycles
        id_set(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
        step();
        id_set(5'd2, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        mem_busy = 1'b1;
        #2;
        chk("t3_busy_stall_0", stall, 1);
        chk("t3_busy_count_0", stall_count, exp_cnt);
        for (int i = 1; i < 4; i++) begin
            step();
            #2;
            chk($sformatf("t3_busy_stall_%0d", i), stall, 1);
            chk($sformatf("t3_busy_count_%0d", i), stall_count, exp_cnt);
        end
        step();
        mem_busy = 1'b0;
        #2 chk("t3_free_stall_0", stall, 1);
        step();
        #2;
`ifdef HAZARD_FORWARD_EN
        exp_cnt = exp_cnt + 1;
        chk("t3_resolved_stall", stall, 0);
        chk("t3_resolved_rt_sel", fwd_rt_sel, 2);
`else
        chk("t3_free_stall_1", stall, 1);
        step();
        #2 chk("t3_free_stall_2", stall, 1);
        step();
        #2;
        exp_cnt = exp_cnt + 3;
        chk("t3_resolved_stall", stall, 0);
        chk("t3_resolved_rt_sel", fwd_rt_sel, 0);
`endif
        chk("t3_count", stall_count, exp_cnt);
        step();
        id_clear();
        repeat (4) step();

        // Flushed load leaves a bubble; flush overrides a live hazard
        id_set(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1);
        flush = 1'b1;
        #2 chk("t4_flush_stall", stall, 0);
        step();
        flush = 1'b0;
        id_set(5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        #2;
        chk("t4_after_stall", stall, 0);
        chk("t4_after_rs_sel", fwd_rs_sel, 0);
        chk("t4_after_rt_sel", fwd_rt_sel, 0);
        step();
        id_set(5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b1);
        step();
        id_set(5'd11, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
        flush = 1'b1;
        #2;
        chk("t4_flush_haz_stall", stall, 0);
        chk("t4_flush_haz_rs_sel", fwd_rs_sel, 0);
        step();
        flush = 1'b0;
        id_clear();
        #2 chk("t4_count", stall_count, exp_cnt);
        repeat (4) step();

        // Reset asserted in the middle of a load-use stall
        id_set(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b1);
        step();
        id_set(5'd10, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        #2 chk("t5_pre_stall", stall, 1);
        step();
        exp_cnt = exp_cnt + 1;
        #2 chk("t5_pre_count", stall_count, exp_cnt);
        #1 rst_b = 1'b0;
        #1;
        chk("t5_rst_stall", stall, 0);
        chk("t5_rst_count", stall_count, 0);
        chk("t5_rst_rs_sel", fwd_rs_sel, 0);
        #1 rst_b = 1'b1;
        step();
        #2 chk("t5_post_stall", stall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
